// File: rtl/evb_arbiter_pkg.sv
// Shared types and constants for the EVB round-robin arbiter.
// State encodings, EVB write-mask codes and the timeout read-data pattern.
package evb_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_e;

    localparam logic [1:0] EVB_MASK_DUMMY = 2'b00;
    localparam logic [1:0] EVB_MASK_L     = 2'b01;
    localparam logic [1:0] EVB_MASK_H     = 2'b10;
    localparam logic [1:0] EVB_MASK_W     = 2'b11;

    localparam logic [31:0] EVB_ARB_TIMEOUT_VAL = 32'hDEADBEEF;

endpackage

// File: rtl/evb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr_i,
// wrapping to the lowest set request when nothing above ptr_i is pending.
module evb_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic            valid_o,
    output logic [IDXW-1:0] idx_o
);

    logic            hi_v;
    logic            lo_v;
    logic [IDXW-1:0] hi_idx;
    logic [IDXW-1:0] lo_idx;

    // hi_* covers the slots after the pointer, lo_* is the wrapped fallback.
    always_comb begin
        hi_v   = 1'b0;
        lo_v   = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_i[i] && (IDXW'(i) > ptr_i) && !hi_v) begin
                hi_v   = 1'b1;
                hi_idx = IDXW'(i);
            end
            if (req_i[i] && !lo_v) begin
                lo_v   = 1'b1;
                lo_idx = IDXW'(i);
            end
        end
        valid_o = hi_v | lo_v;
        idx_o   = hi_v ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/evb_arbiter.sv
// Round-robin arbiter sharing one EVB target among NREQ request/finish requesters.
// Optional watchdog enabled by defining EVB_ARB_TIMEOUT_EN.
module evb_arbiter
    import evb_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      s_request,
    input  logic [16*NREQ-1:0]   s_addr,
    input  logic [2*NREQ-1:0]    s_wr_mask,
    input  logic [32*NREQ-1:0]   s_wr_data,
    output logic [NREQ-1:0]      s_finish,
    output logic [31:0]          s_rd_data,
    output logic                 m_request,
    output logic [15:0]          m_addr,
    output logic [1:0]           m_wr_mask,
    output logic [31:0]          m_wr_data,
    input  logic                 m_finish,
    input  logic [31:0]          m_rd_data,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 err
);

    localparam int IDXW = $clog2(NREQ);

    arb_state_e      state_q;
    logic [IDXW-1:0] ptr_q;
    logic [2:0]      grant_q;
    logic [NREQ-1:0] s_finish_q;
    logic [31:0]     s_rd_data_q;
    logic            m_request_q;
    logic [15:0]     m_addr_q;
    logic [1:0]      m_wr_mask_q;
    logic [31:0]     m_wr_data_q;

    logic            pick_valid;
    logic [IDXW-1:0] pick_idx;
    logic [15:0]     sel_addr_d;
    logic [1:0]      sel_mask_d;
    logic [31:0]     sel_data_d;
    logic [NREQ-1:0] finish_vec_d;

`ifdef EVB_ARB_TIMEOUT_EN
    logic [15:0]     cnt_q;
    logic            err_q;
`endif

    evb_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i   (s_request),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        sel_addr_d   = '0;
        sel_mask_d   = '0;
        sel_data_d   = '0;
        finish_vec_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDXW'(i)) begin
                sel_addr_d = s_addr[16*i +: 16];
                sel_mask_d = s_wr_mask[2*i +: 2];
                sel_data_d = s_wr_data[32*i +: 32];
            end
            finish_vec_d[i] = (grant_q == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= IDXW'(NREQ - 1);
            grant_q     <= '0;
            s_finish_q  <= '0;
            s_rd_data_q <= '0;
            m_request_q <= 1'b0;
            m_addr_q    <= '0;
            m_wr_mask_q <= '0;
            m_wr_data_q <= '0;
`ifdef EVB_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            s_finish_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_q     <= 3'(pick_idx);
                        ptr_q       <= pick_idx;
                        m_request_q <= 1'b1;
                        m_addr_q    <= sel_addr_d;
                        m_wr_mask_q <= sel_mask_d;
                        m_wr_data_q <= sel_data_d;
                        state_q     <= ARB_BUSY;
`ifdef EVB_ARB_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                ARB_BUSY: begin
                    // m_finish wins over a watchdog expiry in the same cycle.
                    if (m_finish) begin
                        s_finish_q  <= finish_vec_d;
                        s_rd_data_q <= m_rd_data;
                        m_request_q <= 1'b0;
                        m_addr_q    <= '0;
                        m_wr_mask_q <= '0;
                        m_wr_data_q <= '0;
                        state_q     <= ARB_RELEASE;
                    end
`ifdef EVB_ARB_TIMEOUT_EN
                    else if (cnt_q == 16'(TIMEOUT - 1)) begin
                        s_finish_q  <= finish_vec_d;
                        s_rd_data_q <= EVB_ARB_TIMEOUT_VAL;
                        m_request_q <= 1'b0;
                        m_addr_q    <= '0;
                        m_wr_mask_q <= '0;
                        m_wr_data_q <= '0;
                        err_q       <= 1'b1;
                        state_q     <= ARB_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                // The finishing requester still holds s_request here, so it is not sampled.
                ARB_RELEASE: state_q <= ARB_IDLE;
                default:     state_q <= ARB_IDLE;
            endcase
        end
    end

    assign s_finish  = s_finish_q;
    assign s_rd_data = s_rd_data_q;
    assign m_request = m_request_q;
    assign m_addr    = m_addr_q;
    assign m_wr_mask = m_wr_mask_q;
    assign m_wr_data = m_wr_data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != ARB_IDLE);

`ifdef EVB_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_evb_arbiter.sv
// Directed bench for evb_arbiter: expected finishes are queued by the stimulus
// and popped by an independent monitor whenever s_finish fires.
module tb_evb_arbiter;
    import evb_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int TMO  = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      s_request;
    logic [16*NREQ-1:0]   s_addr;
    logic [2*NREQ-1:0]    s_wr_mask;
    logic [32*NREQ-1:0]   s_wr_data;
    logic [NREQ-1:0]      s_finish;
    logic [31:0]          s_rd_data;
    logic                 m_request;
    logic [15:0]          m_addr;
    logic [1:0]           m_wr_mask;
    logic [31:0]          m_wr_data;
    logic                 m_finish;
    logic [31:0]          m_rd_data;
    logic [2:0]           grant_id;
    logic                 busy;
    logic                 err;

    evb_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_request (s_request),
        .s_addr    (s_addr),
        .s_wr_mask (s_wr_mask),
        .s_wr_data (s_wr_data),
        .s_finish  (s_finish),
        .s_rd_data (s_rd_data),
        .m_request (m_request),
        .m_addr    (m_addr),
        .m_wr_mask (m_wr_mask),
        .m_wr_data (m_wr_data),
        .m_finish  (m_finish),
        .m_rd_data (m_rd_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .err       (err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [34:0] exp_q[$];   // {requester id, read data}
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin : monitor
        logic [34:0]     e;
        logic [NREQ-1:0] ev;
        forever begin
            @(negedge clk);
            if (s_finish != '0) begin
                if (exp_q.size() == 0) begin
                    check("finish_unexpected", 64'(s_finish), 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ev = '0;
                    ev[e[34:32]] = 1'b1;
                    check("finish_vec", 64'(s_finish), 64'(ev));
                    check("finish_gid", 64'(grant_id), 64'(e[34:32]));
                    check("finish_rd", 64'(s_rd_data), 64'(e[31:0]));
                end
            end
        end
    end

    // ---------------- target model ----------------
    bit          tgt_en;
    bit          tgt_addr_mode;
    bit          tgt_spur;
    int          tgt_delay;
    logic [31:0] tgt_data;
    int          tcnt;

    initial begin : target
        m_finish  = 1'b0;
        m_rd_data = '0;
        tcnt      = 0;
        forever begin
            @(posedge clk);
            #1;
            m_finish = 1'b0;
            if (tgt_spur) begin
                m_finish  = 1'b1;
                m_rd_data = 32'hBAD0BAD0;
                tgt_spur  = 1'b0;
            end else if (m_request && tgt_en) begin
                tcnt++;
                if (tcnt == tgt_delay) begin
                    m_finish  = 1'b1;
                    m_rd_data = tgt_addr_mode ? {16'hA5A5, m_addr} : tgt_data;
                end
            end else begin
                tcnt = 0;
            end
        end
    end

    // ---------------- requester agents ----------------
    int left [NREQ];

    initial begin : requesters
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (s_finish[i]) begin
                    left[i]--;
                    if (left[i] <= 0) s_request[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst       = 1'b1;
        s_request = '0;
        for (int i = 0; i < NREQ; i++) left[i] = 0;
        tgt_en    = 1'b0;
        tgt_spur  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_slot(input int i, input logic [15:0] a, input logic [1:0] m, input logic [31:0] d);
        s_addr[16*i +: 16]    = a;
        s_wr_mask[2*i +: 2]   = m;
        s_wr_data[32*i +: 32] = d;
    endtask

    task automatic issue(input int i, input int n);
        left[i]      = n;
        s_request[i] = 1'b1;
    endtask

    task automatic push_exp(input int id, input logic [31:0] d);
        exp_q.push_back({3'(id), d});
    endtask

    task automatic wait_m_request(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (m_request) return;
        end
        check("wait_m_request_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_finish(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (s_finish != '0) return;
        end
        check("wait_finish_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && s_request == '0) return;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin : main
        int t_fin;
        int bcnt;
        s_addr    = '0;
        s_wr_mask = '0;
        s_wr_data = '0;
        tgt_delay = 1;
        tgt_data  = '0;
        tgt_addr_mode = 1'b0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_m_request", 64'(m_request), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_grant_id",  64'(grant_id),  64'd0);
        check("rst_s_finish",  64'(s_finish),  64'd0);
        check("rst_m_addr",    64'(m_addr),    64'd0);
        check("rst_rd_data",   64'(s_rd_data), 64'd0);
        check("rst_err",       64'(err),       64'd0);

        // Single read, twice back-to-back, target finishes 3 cycles after m_request
        tgt_en = 1'b1; tgt_delay = 3; tgt_addr_mode = 1'b0; tgt_data = 32'hCAFE0001;
        set_slot(0, 16'h0120, EVB_MASK_DUMMY, 32'h0);
        push_exp(0, 32'hCAFE0001);
        push_exp(0, 32'hCAFE0001);
        @(posedge clk); #1 issue(0, 2);
        @(negedge clk);
        check("lat_before_edge", 64'(m_request), 64'd0);
        @(negedge clk);
        check("lat_grant",     64'(m_request), 64'd1);
        check("single_m_addr", 64'(m_addr),    64'h0120);
        check("single_m_mask", 64'(m_wr_mask), 64'(EVB_MASK_DUMMY));
        check("single_busy",   64'(busy),      64'd1);
        wait_finish(20);
        t_fin = cyc;
        @(negedge clk);
        check("finish_one_cycle", 64'(s_finish), 64'd0);
        check("rd_data_hold",     64'(s_rd_data), 64'hCAFE0001);
        if (!m_request) wait_m_request(20);
        check("regrant_gap", 64'(cyc - t_fin), 64'd2);
        wait_drain(50);

        // Contention: both request together, each re-requests once
        do_reset();
        tgt_en = 1'b1; tgt_delay = 1; tgt_addr_mode = 1'b1;
        set_slot(0, 16'h0010, EVB_MASK_W, 32'h11110000);
        set_slot(1, 16'h0020, EVB_MASK_L, 32'h22220000);
        push_exp(0, 32'hA5A50010);
        push_exp(1, 32'hA5A50020);
        push_exp(0, 32'hA5A50010);
        push_exp(1, 32'hA5A50020);
        @(posedge clk); #1 begin issue(0, 2); issue(1, 2); end
        wait_drain(100);

        // Write forwarding from requester 1, held stable for every BUSY cycle
        do_reset();
        tgt_en = 1'b1; tgt_delay = 4; tgt_addr_mode = 1'b0; tgt_data = 32'h12345678;
        set_slot(0, 16'hFFFF, EVB_MASK_W, 32'hFFFFFFFF);
        set_slot(1, 16'h0344, EVB_MASK_H, 32'h0000BEEF);
        push_exp(1, 32'h12345678);
        @(posedge clk); #1 issue(1, 1);
        wait_m_request(20);
        bcnt = 0;
        for (int k = 0; k < 20 && m_request; k++) begin
            check("wr_m_addr", 64'(m_addr),    64'h0344);
            check("wr_m_mask", 64'(m_wr_mask), 64'(EVB_MASK_H));
            check("wr_m_data", 64'(m_wr_data), 64'h0000BEEF);
            check("wr_gid",    64'(grant_id),  64'd1);
            bcnt++;
            @(negedge clk);
        end
        check("wr_busy_cycles", 64'(bcnt), 64'd4);
        wait_drain(50);

        // Reset two cycles after grant, coinciding with m_finish: reset wins
        do_reset();
        tgt_en = 1'b1; tgt_delay = 2; tgt_addr_mode = 1'b0; tgt_data = 32'h0BAD0BAD;
        set_slot(0, 16'h0400, EVB_MASK_W, 32'h44440000);
        set_slot(1, 16'h0500, EVB_MASK_W, 32'h55550000);
        @(posedge clk); #1 issue(0, 1);
        wait_m_request(20);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 begin rst = 1'b0; s_request = '0; left[0] = 0; end
        @(negedge clk);
        check("mid_rst_m_request", 64'(m_request), 64'd0);
        check("mid_rst_m_addr",    64'(m_addr),    64'd0);
        check("mid_rst_m_data",    64'(m_wr_data), 64'd0);
        check("mid_rst_s_finish",  64'(s_finish),  64'd0);
        check("mid_rst_busy",      64'(busy),      64'd0);
        check("mid_rst_grant_id",  64'(grant_id),  64'd0);

        // Spurious m_finish while idle is ignored
        tgt_spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("spurious_s_finish", 64'(s_finish), 64'd0);
            check("spurious_busy",     64'(busy),     64'd0);
        end

        // After reset both request: requester 0 must win first
        tgt_addr_mode = 1'b1;
        push_exp(0, 32'hA5A50400);
        push_exp(1, 32'hA5A50500);
        @(posedge clk); #1 begin issue(0, 1); issue(1, 1); end
        wait_drain(100);

`ifdef EVB_ARB_TIMEOUT_EN
        // Target never answers: watchdog finishes after TMO BUSY cycles
        do_reset();
        tgt_en = 1'b0;
        set_slot(0, 16'h0600, EVB_MASK_DUMMY, 32'h0);
        push_exp(0, EVB_ARB_TIMEOUT_VAL);
        @(posedge clk); #1 issue(0, 1);
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_request) bcnt++;
            if (s_finish != '0) break;
        end
        check("tmo_busy_cycles", 64'(bcnt), 64'(TMO));
        check("tmo_err_set",     64'(err),  64'd1);
        repeat (5) @(negedge clk);
        check("tmo_err_sticky",  64'(err),  64'd1);
        wait_drain(50);

        // m_finish on the TMO-th BUSY cycle beats the watchdog
        do_reset();
        tgt_en = 1'b1; tgt_delay = TMO; tgt_addr_mode = 1'b0; tgt_data = 32'h600D0008;
        push_exp(0, 32'h600D0008);
        @(posedge clk); #1 issue(0, 1);
        wait_drain(60);
        check("tmo_race_err", 64'(err), 64'd0);
`else
        check("no_tmo_err_tied", 64'(err), 64'd0);
`endif

        repeat (3) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
